// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/bubble/flush sequencer with stall/flush counters and cache watchdog
module hazard_ctrl #(
  parameter int LU_STALLS = 1,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             branch_taken_i,
  input  logic             dcache_stall_i,
  input  logic             clr_cnt_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_stall_o,
  output logic             idex_bubble_o,
  output logic             exmem_stall_o,
  output logic             memwb_stall_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             mem_timeout_o
);

  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WMAX  = WW'(TIMEOUT);
  localparam logic [WW-1:0] WLAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [1:0] BUB_INIT = 2'(LU_STALLS - 1);

  typedef enum logic [1:0] {RUN, BUBBLE, FREEZE} state_t;

  state_t          state;
  state_t          ret_state;
  state_t          eff_state;
  logic [1:0]      bub_cnt;
  logic [WW-1:0]   wait_cnt;
  logic            load_use;

  assign load_use = idex_memread_i && (idex_rt_i != 5'd0) &&
                    ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

  // Leaving FREEZE, the release cycle already behaves like the saved state.
  assign eff_state = (state == FREEZE) ? ret_state : state;

  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_stall_o  = 1'b0;
    idex_bubble_o = 1'b0;
    exmem_stall_o = 1'b0;
    memwb_stall_o = 1'b0;
    if (!rst_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (dcache_stall_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_stall_o  = 1'b1;
      exmem_stall_o = 1'b1;
      memwb_stall_o = 1'b1;
    end else if (eff_state == BUBBLE || load_use) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= RUN;
      ret_state <= RUN;
      bub_cnt   <= 2'd0;
    end else if (dcache_stall_i) begin
      if (state != FREEZE) ret_state <= state;
      state <= FREEZE;
    end else begin
      case (eff_state)
        BUBBLE: begin
          if (bub_cnt <= 2'd1) begin
            state   <= RUN;
            bub_cnt <= 2'd0;
          end else begin
            state   <= BUBBLE;
            bub_cnt <= bub_cnt - 2'd1;
          end
        end
        default: begin
          if (load_use && LU_STALLS == 2) begin
            state   <= BUBBLE;
            bub_cnt <= BUB_INIT;
          end else begin
            state   <= RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else if (clr_cnt_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!pc_write_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (ifid_flush_o && flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end

  // Sticky flag sets on the edge at which the wait count reaches TIMEOUT.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wait_cnt      <= '0;
      mem_timeout_o <= 1'b0;
    end else begin
      if (dcache_stall_i) begin
        if (wait_cnt != WMAX) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (TIMEOUT != 0 && dcache_stall_i && wait_cnt == WLAST) mem_timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with LU_STALLS=1 and LU_STALLS=2 instances
module tb_hazard_ctrl;

  localparam logic [6:0] NORM = 7'b1100000;
  localparam logic [6:0] LU   = 7'b0000100;
  localparam logic [6:0] BR   = 7'b1110000;
  localparam logic [6:0] FRZ  = 7'b0001011;
  localparam logic [6:0] RST  = 7'b0010100;

  typedef struct {
    string      name;
    int         sel;
    logic [6:0] ctl;
    int         scnt;
    int         fcnt;
    int         to;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       idex_memread_i = 1'b0;
  logic [4:0] idex_rt_i = 5'd0;
  logic [4:0] ifid_rs_i = 5'd0;
  logic [4:0] ifid_rt_i = 5'd0;
  logic       branch_taken_i = 1'b0;
  logic       dcache_stall_i = 1'b0;
  logic       clr_cnt_i = 1'b0;

  logic       pc1, iw1, fl1, is1, bb1, em1, mw1, to1;
  logic [3:0] sc1, fc1;
  logic       pc2, iw2, fl2, is2, bb2, em2, mw2, to2;
  logic [15:0] sc2, fc2;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(.LU_STALLS(1), .CNT_W(4), .TIMEOUT(4)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
    .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i), .branch_taken_i(branch_taken_i),
    .dcache_stall_i(dcache_stall_i), .clr_cnt_i(clr_cnt_i),
    .pc_write_o(pc1), .ifid_write_o(iw1), .ifid_flush_o(fl1), .idex_stall_o(is1),
    .idex_bubble_o(bb1), .exmem_stall_o(em1), .memwb_stall_o(mw1),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1), .mem_timeout_o(to1)
  );

  hazard_ctrl #(.LU_STALLS(2), .CNT_W(16), .TIMEOUT(0)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
    .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i), .branch_taken_i(branch_taken_i),
    .dcache_stall_i(dcache_stall_i), .clr_cnt_i(clr_cnt_i),
    .pc_write_o(pc2), .ifid_write_o(iw2), .ifid_flush_o(fl2), .idex_stall_o(is2),
    .idex_bubble_o(bb2), .exmem_stall_o(em2), .memwb_stall_o(mw2),
    .stall_cnt_o(sc2), .flush_cnt_o(fc2), .mem_timeout_o(to2)
  );

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (q.size() > 0) begin
      exp_t       e;
      logic [6:0] a_ctl;
      int         a_sc, a_fc, a_to;
      e = q.pop_front();
      if (e.sel == 1) begin
        a_ctl = {pc1, iw1, fl1, is1, bb1, em1, mw1};
        a_sc = int'(sc1); a_fc = int'(fc1); a_to = int'(to1);
      end else begin
        a_ctl = {pc2, iw2, fl2, is2, bb2, em2, mw2};
        a_sc = int'(sc2); a_fc = int'(fc2); a_to = int'(to2);
      end
      checks++;
      if (a_ctl !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl actual=%b required=%b", e.name, a_ctl, e.ctl);
      end
      if (e.scnt >= 0) begin
        checks++;
        if (a_sc != e.scnt) begin
          errors++;
          $display("FAIL %s stall_cnt actual=%0d required=%0d", e.name, a_sc, e.scnt);
        end
      end
      if (e.fcnt >= 0) begin
        checks++;
        if (a_fc != e.fcnt) begin
          errors++;
          $display("FAIL %s flush_cnt actual=%0d required=%0d", e.name, a_fc, e.fcnt);
        end
      end
      if (e.to >= 0) begin
        checks++;
        if (a_to != e.to) begin
          errors++;
          $display("FAIL %s timeout actual=%0d required=%0d", e.name, a_to, e.to);
        end
      end
    end
  end

  task automatic step(input string nm, input int sel, input logic rst, input logic mr,
                      input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] frt,
                      input logic br, input logic dc, input logic clr,
                      input logic [6:0] ctl, input int sc, input int fc, input int to);
    exp_t e;
    rst_i = rst; idex_memread_i = mr; idex_rt_i = rt; ifid_rs_i = rs; ifid_rt_i = frt;
    branch_taken_i = br; dcache_stall_i = dc; clr_cnt_i = clr;
    e.name = nm; e.sel = sel; e.ctl = ctl; e.scnt = sc; e.fcnt = fc; e.to = to;
    q.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    @(posedge clk_i);
    #1;
    // LU_STALLS=1, CNT_W=4, TIMEOUT=4
    step("a_reset",  1, 0, 0, 0, 0, 0, 0, 0, 0, RST,  0, 0, 0);
    step("a_idle",   1, 1, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 0);
    step("a_lu",     1, 1, 1, 5, 5, 0, 0, 0, 0, LU,   0, 0, -1);
    step("a_lu_rel", 1, 1, 0, 0, 0, 0, 0, 0, 0, NORM, 1, 0, -1);
    step("a_rt0",    1, 1, 1, 0, 0, 0, 0, 0, 0, NORM, 1, -1, -1);
    step("a_br_lu",  1, 1, 1, 7, 3, 7, 1, 0, 0, LU,   1, 0, -1);
    step("a_br",     1, 1, 0, 0, 0, 0, 1, 0, 0, BR,   2, 0, -1);
    step("a_br_cnt", 1, 1, 0, 0, 0, 0, 0, 0, 0, NORM, 2, 1, 0);
    step("a_frz1",   1, 1, 0, 0, 0, 0, 0, 1, 0, FRZ,  2, 1, 0);
    step("a_frz2",   1, 1, 0, 0, 0, 0, 0, 1, 0, FRZ,  3, 1, 0);
    step("a_frz3",   1, 1, 0, 0, 0, 0, 0, 1, 0, FRZ,  4, 1, 0);
    step("a_frz4",   1, 1, 0, 0, 0, 0, 0, 1, 0, FRZ,  5, 1, 0);
    step("a_frz5",   1, 1, 0, 0, 0, 0, 0, 1, 0, FRZ,  6, 1, 1);
    step("a_to_st1", 1, 1, 0, 0, 0, 0, 0, 0, 0, NORM, 7, 1, 1);
    step("a_to_st2", 1, 1, 0, 0, 0, 0, 0, 0, 0, NORM, 7, 1, 1);
    for (int i = 0; i < 20; i++)
      step("a_sat", 1, 1, 1, 5, 5, 0, 0, 0, 0, LU, (7 + i > 15) ? 15 : 7 + i, 1, 1);
    step("a_clr",    1, 1, 1, 5, 5, 0, 0, 0, 1, LU,   15, 1, 1);
    step("a_clr_ch", 1, 1, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 1);
    step("a_rst_to", 1, 0, 0, 0, 0, 0, 0, 0, 0, RST,  0, 0, 0);
    // LU_STALLS=2, CNT_W=16, watchdog disabled
    step("b_reset",  2, 0, 0, 0, 0, 0, 0, 0, 0, RST,  0, 0, 0);
    step("b_lu",     2, 1, 1, 5, 5, 0, 0, 0, 0, LU,   0, 0, 0);
    step("b_frz1",   2, 1, 0, 0, 0, 0, 0, 1, 0, FRZ,  1, 0, 0);
    step("b_frz2",   2, 1, 0, 0, 0, 0, 0, 1, 0, FRZ,  2, 0, 0);
    step("b_frz3",   2, 1, 0, 0, 0, 0, 0, 1, 0, FRZ,  3, 0, 0);
    step("b_bub2",   2, 1, 0, 0, 0, 0, 1, 0, 0, LU,   4, 0, 0);
    step("b_run",    2, 1, 0, 0, 0, 0, 0, 0, 0, NORM, 5, 0, 0);
    step("b_lu2",    2, 1, 1, 9, 0, 9, 0, 0, 0, LU,   5, 0, -1);
    step("b_rst_mb", 2, 0, 0, 0, 0, 0, 0, 0, 0, RST,  0, 0, -1);
    step("b_post",   2, 1, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, -1);
    step("b_frz_br", 2, 1, 0, 0, 0, 0, 1, 1, 0, FRZ,  0, 0, -1);
    step("b_rel_br", 2, 1, 0, 0, 0, 0, 1, 0, 0, BR,   1, 0, -1);
    step("b_end",    2, 1, 0, 0, 0, 0, 0, 0, 0, NORM, 1, 1, 0);
    repeat (3) @(posedge clk_i);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
